// File: rtl/disp_sched_pkg.sv
// Shared constants and types for the display scheduler: source indices,
// blank encodings and scheduler state encodings.
package disp_pkg;

  localparam logic [1:0] SRC_CLK   = 2'd0;
  localparam logic [1:0] SRC_ALM   = 2'd1;
  localparam logic [1:0] SRC_SW    = 2'd2;

  localparam logic [6:0] SEG_BLANK = 7'b111_1111;
  localparam logic       DOT_OFF   = 1'b1;
  localparam logic       PHASE_ON  = 1'b1;

  typedef enum logic {
    ST_NORMAL  = 1'b0,
    ST_OVERLAY = 1'b1
  } disp_state_e;

  // One bit per digit of the pair currently being set
  function automatic logic [7:0] pair_mask(input logic [1:0] sel);
    return 8'b0000_0011 << {sel, 1'b0};
  endfunction

endpackage

// File: rtl/disp_sched_blink_tick.sv
// Free-running blink phase generator: half-period divider with restart,
// phase toggle and a one-cycle tick on every wrap.
module disp_blink_tick
  import disp_pkg::*;
#(
  parameter int CLK_Freq   = 100000000,
  parameter int BLINK_Freq = 2,
  parameter int N          = 26
) (
  input  logic CP_100MHz,
  input  logic CLR,
  input  logic RESTART,
  output logic PHASE,
  output logic TICK
);

  localparam int           HALF     = CLK_Freq / (2 * BLINK_Freq);
  localparam logic [N-1:0] DIV_LAST = N'(HALF - 1);

  logic [N-1:0] div_r;
  logic         phase_r;
  logic         wrap_s;

  assign wrap_s = (div_r == DIV_LAST) && !RESTART;

  // Divider and phase register; restart re-aligns the phase to ON
  always_ff @(posedge CP_100MHz) begin
    if (CLR) begin
      div_r   <= {N{1'b0}};
      phase_r <= PHASE_ON;
    end else if (RESTART) begin
      div_r   <= {N{1'b0}};
      phase_r <= PHASE_ON;
    end else if (wrap_s) begin
      div_r   <= {N{1'b0}};
      phase_r <= ~phase_r;
    end else begin
      div_r   <= div_r + N'(1);
    end
  end

  assign PHASE = phase_r;
  assign TICK  = wrap_s;

endmodule

// File: rtl/disp_sched.sv
// Display scheduler: picks one of three frame sources by mode, blinks the
// digit pair being set, and overlays a timed full-display alarm blink.
module disp_sched
  import disp_pkg::*;
#(
  parameter int CLK_Freq    = 100000000,
  parameter int BLINK_Freq  = 2,
  parameter int OVL_TOGGLES = 20,
  parameter int N           = 26
) (
  input  logic        CP_100MHz,
  input  logic        CLR,
  input  logic        MODE_P,
  input  logic        ALARM_REQ,
  input  logic        ACK_P,
  input  logic        SET_EN,
  input  logic [1:0]  SET_SEL,
  input  logic [55:0] FRM0,
  input  logic [55:0] FRM1,
  input  logic [55:0] FRM2,
  input  logic [7:0]  DOTS0,
  input  logic [7:0]  DOTS1,
  input  logic [7:0]  DOTS2,
  output logic [6:0]  SEG7,
  output logic [6:0]  SEG6,
  output logic [6:0]  SEG5,
  output logic [6:0]  SEG4,
  output logic [6:0]  SEG3,
  output logic [6:0]  SEG2,
  output logic [6:0]  SEG1,
  output logic [6:0]  SEG0,
  output logic [7:0]  DOT,
  output logic [1:0]  MODE,
  output logic        OVL
);

  localparam int            CW       = $clog2(OVL_TOGGLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(OVL_TOGGLES - 1);

  disp_state_e state_r, state_nxt_s;
  logic [1:0]    mode_r, mode_nxt_s, src_sel_s;
  logic [CW-1:0] cnt_r, cnt_nxt_s;
  logic          alarm_q_r, alarm_rise_s, restart_s;
  logic          phase_s, tick_s;
  logic [55:0]   seg_r, seg_nxt_s, frm_s;
  logic [7:0]    dot_r, dot_nxt_s, dots_s, mask_s;
  logic          ovl_r;

  disp_blink_tick #(
    .CLK_Freq   (CLK_Freq),
    .BLINK_Freq (BLINK_Freq),
    .N          (N)
  ) u_blink (
    .CP_100MHz (CP_100MHz),
    .CLR       (CLR),
    .RESTART   (restart_s),
    .PHASE     (phase_s),
    .TICK      (tick_s)
  );

  assign alarm_rise_s = ALARM_REQ && !alarm_q_r;
  assign mask_s       = pair_mask(SET_SEL);

  // Next state, mode stepping and overlay toggle counting
  always_comb begin
    state_nxt_s = state_r;
    mode_nxt_s  = mode_r;
    cnt_nxt_s   = cnt_r;
    restart_s   = 1'b0;
    case (state_r)
      ST_NORMAL: begin
        if (MODE_P) begin
          mode_nxt_s = (mode_r == SRC_SW) ? SRC_CLK : mode_r + 2'd1;
        end else begin
          mode_nxt_s = mode_r;
        end
        // ACK in the same cycle as the rising edge suppresses entry
        if (alarm_rise_s && !ACK_P) begin
          state_nxt_s = ST_OVERLAY;
          restart_s   = 1'b1;
          cnt_nxt_s   = {CW{1'b0}};
        end else begin
          state_nxt_s = ST_NORMAL;
        end
      end
      ST_OVERLAY: begin
        if (tick_s) begin
          cnt_nxt_s = cnt_r + CW'(1);
        end else begin
          cnt_nxt_s = cnt_r;
        end
        if (ACK_P || !ALARM_REQ || (tick_s && (cnt_r == CNT_LAST))) begin
          state_nxt_s = ST_NORMAL;
        end else begin
          state_nxt_s = ST_OVERLAY;
        end
      end
      default: begin
        state_nxt_s = ST_NORMAL;
      end
    endcase
  end

  // Frame selection and blanking for the next output register load
  always_comb begin
    src_sel_s = (state_r == ST_OVERLAY) ? SRC_ALM : mode_r;
    case (src_sel_s)
      SRC_CLK: begin frm_s = FRM0; dots_s = DOTS0; end
      SRC_ALM: begin frm_s = FRM1; dots_s = DOTS1; end
      SRC_SW:  begin frm_s = FRM2; dots_s = DOTS2; end
      default: begin frm_s = {8{SEG_BLANK}}; dots_s = {8{DOT_OFF}}; end
    endcase
    seg_nxt_s = frm_s;
    dot_nxt_s = dots_s;
    if (state_r == ST_OVERLAY) begin
      if (phase_s != PHASE_ON) begin
        seg_nxt_s = {8{SEG_BLANK}};
        dot_nxt_s = {8{DOT_OFF}};
      end else begin
        seg_nxt_s = frm_s;
        dot_nxt_s = dots_s;
      end
    end else if (SET_EN && (phase_s != PHASE_ON)) begin
      for (int i = 0; i < 8; i++) begin
        if (mask_s[i]) begin
          seg_nxt_s[i*7 +: 7] = SEG_BLANK;
          dot_nxt_s[i]        = DOT_OFF;
        end else begin
          seg_nxt_s[i*7 +: 7] = frm_s[i*7 +: 7];
          dot_nxt_s[i]        = dots_s[i];
        end
      end
    end else begin
      seg_nxt_s = frm_s;
      dot_nxt_s = dots_s;
    end
  end

  // State register
  always_ff @(posedge CP_100MHz) begin
    if (CLR) begin
      state_r <= ST_NORMAL;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Mode, counter, alarm sample and registered display outputs
  always_ff @(posedge CP_100MHz) begin
    if (CLR) begin
      mode_r    <= SRC_CLK;
      cnt_r     <= {CW{1'b0}};
      alarm_q_r <= 1'b0;
      seg_r     <= {8{SEG_BLANK}};
      dot_r     <= {8{DOT_OFF}};
      ovl_r     <= 1'b0;
    end else begin
      mode_r    <= mode_nxt_s;
      cnt_r     <= cnt_nxt_s;
      alarm_q_r <= ALARM_REQ;
      seg_r     <= seg_nxt_s;
      dot_r     <= dot_nxt_s;
      ovl_r     <= (state_r == ST_OVERLAY);
    end
  end

  assign {SEG7, SEG6, SEG5, SEG4, SEG3, SEG2, SEG1, SEG0} = seg_r;
  assign DOT  = dot_r;
  assign MODE = mode_r;
  assign OVL  = ovl_r;

endmodule

// File: tb/tb_disp_sched.sv
// Directed self-checking bench for disp_sched with a 4-cycle blink half
// period and a 3-toggle overlay lifetime.
module tb_disp_sched;

  logic        clk = 1'b0;
  logic        CLR = 1'b1, MODE_P = 1'b0, ALARM_REQ = 1'b0, ACK_P = 1'b0, SET_EN = 1'b0;
  logic [1:0]  SET_SEL = 2'd0;
  logic [55:0] FRM0, FRM1, FRM2;
  logic [7:0]  DOTS0, DOTS1, DOTS2;
  logic [6:0]  SEG7, SEG6, SEG5, SEG4, SEG3, SEG2, SEG1, SEG0;
  logic [7:0]  DOT;
  logic [1:0]  MODE;
  logic        OVL;
  logic [55:0] seg_all;

  localparam logic [55:0] F0    = {8{7'h40}};
  localparam logic [55:0] F1    = {7'h17, 7'h16, 7'h15, 7'h14, 7'h13, 7'h12, 7'h11, 7'h10};
  localparam logic [55:0] F1_SB = {7'h17, 7'h16, 7'h7F, 7'h7F, 7'h13, 7'h12, 7'h11, 7'h10};
  localparam logic [55:0] F2    = {8{7'h5B}};
  localparam logic [55:0] BLANK = {8{7'h7F}};

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int base    = 0;
  int e_ent   = 0;
  logic p;
  logic [1:0]  exp_mode [4] = '{2'd1, 2'd2, 2'd0, 2'd1};
  logic [55:0] exp_frm  [4];

  always #5 clk = ~clk;

  assign seg_all = {SEG7, SEG6, SEG5, SEG4, SEG3, SEG2, SEG1, SEG0};

  disp_sched #(
    .CLK_Freq    (8),
    .BLINK_Freq  (1),
    .OVL_TOGGLES (3),
    .N           (26)
  ) dut (
    .CP_100MHz (clk), .CLR (CLR), .MODE_P (MODE_P), .ALARM_REQ (ALARM_REQ),
    .ACK_P (ACK_P), .SET_EN (SET_EN), .SET_SEL (SET_SEL),
    .FRM0 (FRM0), .FRM1 (FRM1), .FRM2 (FRM2),
    .DOTS0 (DOTS0), .DOTS1 (DOTS1), .DOTS2 (DOTS2),
    .SEG7 (SEG7), .SEG6 (SEG6), .SEG5 (SEG5), .SEG4 (SEG4),
    .SEG3 (SEG3), .SEG2 (SEG2), .SEG1 (SEG1), .SEG0 (SEG0),
    .DOT (DOT), .MODE (MODE), .OVL (OVL)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_tests++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    cyc = cyc + 1;
    #1;
  endtask

  // Phase ON after edge e when the divider was last restarted at edge b
  function automatic logic ph_after(input int e, input int b);
    return (((e - b) / 4) % 2) == 0;
  endfunction

  initial begin
    FRM0 = F0; FRM1 = F1; FRM2 = F2;
    DOTS0 = 8'hF0; DOTS1 = 8'hAA; DOTS2 = 8'h0F;
    exp_frm = '{F1, F2, F0, F1};

    // Reset
    step(); step();
    base = cyc;
    chk("rst_seg", seg_all, BLANK);
    chk("rst_dot", DOT, 8'hFF);
    chk("rst_mode", MODE, 2'd0);
    chk("rst_ovl", OVL, 1'b0);
    CLR = 1'b0;
    step();
    chk("post_rst_seg", seg_all, F0);
    chk("post_rst_dot", DOT, 8'hF0);

    // Mode cycling
    for (int k = 0; k < 4; k++) begin
      MODE_P = 1'b1;
      step();
      MODE_P = 1'b0;
      chk("mode", MODE, exp_mode[k]);
      step();
      chk("mode_frame", seg_all, exp_frm[k]);
    end

    // Set-field blinking on digits 5:4 in mode 1
    SET_EN = 1'b1; SET_SEL = 2'd2;
    for (int k = 0; k < 10; k++) begin
      step();
      p = ph_after(cyc - 1, base);
      chk("set_seg", seg_all, p ? F1 : F1_SB);
      chk("set_dot", DOT, p ? 8'hAA : 8'hBA);
    end
    SET_EN = 1'b0;

    // Overlay expiry in mode 2
    MODE_P = 1'b1; step(); MODE_P = 1'b0;
    chk("mode2", MODE, 2'd2);
    step();
    ALARM_REQ = 1'b1;
    step();
    e_ent = cyc;
    base  = cyc;
    chk("ovl_entry_edge", OVL, 1'b0);
    chk("ovl_entry_seg", seg_all, F2);
    for (int m = 1; m <= 12; m++) begin
      step();
      p = (((m - 1) / 4) % 2) == 0;
      chk("ovl_on", OVL, 1'b1);
      chk("ovl_seg", seg_all, p ? F1 : BLANK);
      chk("ovl_dot", DOT, p ? 8'hAA : 8'hFF);
    end
    step();
    chk("expire_ovl", OVL, 1'b0);
    chk("expire_seg", seg_all, F2);
    chk("expire_dot", DOT, 8'h0F);
    for (int k = 0; k < 10; k++) begin
      step();
      chk("no_reentry", OVL, 1'b0);
    end
    chk("expire_mode", MODE, 2'd2);

    // ACK during overlay; MODE_P ignored while overlaid
    ALARM_REQ = 1'b0; step();
    ALARM_REQ = 1'b1; step();
    MODE_P = 1'b1; step(); MODE_P = 1'b0;
    chk("ack_ovl_up", OVL, 1'b1);
    ACK_P = 1'b1; step(); ACK_P = 1'b0;
    step();
    chk("ack_ovl_down", OVL, 1'b0);
    chk("ack_mode", MODE, 2'd2);
    chk("ack_seg", seg_all, F2);
    step(); step();
    chk("ack_no_reentry", OVL, 1'b0);

    // Rising edge colliding with ACK
    ALARM_REQ = 1'b0; step();
    ALARM_REQ = 1'b1; ACK_P = 1'b1; step(); ACK_P = 1'b0;
    step();
    chk("collide_ovl0", OVL, 1'b0);
    step();
    chk("collide_ovl1", OVL, 1'b0);

    // Reset during overlay
    ALARM_REQ = 1'b0; step();
    ALARM_REQ = 1'b1; step(); step(); step();
    chk("pre_clr_ovl", OVL, 1'b1);
    CLR = 1'b1; ALARM_REQ = 1'b0;
    step();
    chk("clr_seg", seg_all, BLANK);
    chk("clr_dot", DOT, 8'hFF);
    chk("clr_mode", MODE, 2'd0);
    chk("clr_ovl", OVL, 1'b0);
    CLR = 1'b0;
    step(); step();
    chk("after_clr_seg", seg_all, F0);
    chk("after_clr_ovl", OVL, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
